// File: rtl/clk_en_gen_pkg.sv
// Shared types and helpers for the clk_en_gen clock-enable generator.
package clk_en_gen_pkg;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int DEFAULT_ACC_W = 32;

    // Width of the channel-select field; a single channel still needs one bit.
    function automatic int ch_sel_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clk_en_gen_nco.sv
// One NCO channel: phase accumulator, increment register, preload and carry.
// Optional square-wave MSB output is built only when CLK_EN_GEN_SQUARE_EN is defined.
module clk_en_gen_nco
    import clk_en_gen_pkg::*;
#(
    parameter int               ACC_W   = DEFAULT_ACC_W,
    parameter logic [ACC_W-1:0] INC_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [ACC_W-1:0] load_inc,
    input  logic [ACC_W-1:0] load_phase,
`ifdef CLK_EN_GEN_SQUARE_EN
    output logic             msb,
`endif
    output logic             carry
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, inc};

    // Accumulate every cycle; a preload replaces rate and phase and suppresses this cycle's carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            inc   <= INC_RST;
            carry <= 1'b0;
        end else if (load) begin
            acc   <= load_phase;
            inc   <= load_inc;
            carry <= 1'b0;
        end else begin
            acc   <= sum[ACC_W-1:0];
            carry <= sum[ACC_W];
        end
    end

`ifdef CLK_EN_GEN_SQUARE_EN
    logic msb_q;

    // Track the MSB of the new accumulator value as a ~50% duty square wave.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msb_q <= 1'b0;
        end else if (load) begin
            msb_q <= load_phase[ACC_W-1];
        end else begin
            msb_q <= sum[ACC_W-1];
        end
    end

    assign msb = msb_q;
`endif

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel runtime-programmable clock-enable generator on refclk.
// Define CLK_EN_GEN_SQUARE_EN to build per-channel square-wave outputs on clk_out.
module clk_en_gen
    import clk_en_gen_pkg::*;
#(
    parameter int               NUM_CH        = 2,
    parameter int               ACC_W         = DEFAULT_ACC_W,
    parameter int               SETTLE_CYCLES = 16,
    parameter logic [ACC_W-1:0] INC_RST       = '0
) (
    input  logic                             refclk,
    input  logic                             rst,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic [ch_sel_width(NUM_CH)-1:0]  cfg_ch,
    input  logic [ACC_W-1:0]                 cfg_inc,
    input  logic [ACC_W-1:0]                 cfg_phase,
    output logic                             cfg_err,
    output logic [NUM_CH-1:0]                en_out,
    output logic [NUM_CH-1:0]                clk_out,
    output logic                             locked
);

    localparam int                CH_W     = ch_sel_width(NUM_CH);
    localparam int                CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CH_W:0]     CH_LIMIT = (CH_W + 1)'(NUM_CH);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  next_cnt;
    logic              accept;
    logic              reject;
    logic              ch_ok;
    logic              is_locked;
    logic [NUM_CH-1:0] carry;

    assign ch_ok     = ({1'b0, cfg_ch} < CH_LIMIT);
    assign is_locked = (state == ST_LOCKED);
    assign locked    = is_locked;
    assign cfg_ready = is_locked;

    // State and settle-counter registers.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state <= ST_SETTLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Settle countdown and config decode: accepted writes restart the settle window, bad channels are rejected.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            ST_SETTLE: begin
                if (cnt == LAST_CNT) begin
                    next_state = ST_LOCKED;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (cfg_valid) begin
                    if (ch_ok) begin
                        accept     = 1'b1;
                        next_state = ST_SETTLE;
                        next_cnt   = '0;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            default: begin
                next_state = ST_SETTLE;
                next_cnt   = '0;
            end
        endcase
    end

    // One-cycle error pulse following a rejected request.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= reject;
        end
    end

`ifdef CLK_EN_GEN_SQUARE_EN
    logic [NUM_CH-1:0] msb;
`endif

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic load;
        assign load = accept && (cfg_ch == CH_W'(gi));

        clk_en_gen_nco #(
            .ACC_W   (ACC_W),
            .INC_RST (INC_RST)
        ) u_nco (
            .clk        (refclk),
            .rst        (rst),
            .load       (load),
            .load_inc   (cfg_inc),
            .load_phase (cfg_phase),
`ifdef CLK_EN_GEN_SQUARE_EN
            .msb        (msb[gi]),
`endif
            .carry      (carry[gi])
        );
    end

    assign en_out = carry & {NUM_CH{is_locked}};

`ifdef CLK_EN_GEN_SQUARE_EN
    assign clk_out = msb & {NUM_CH{is_locked}};
`else
    assign clk_out = '0;
`endif

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen (ACC_W=8, NUM_CH=3 so that channel 3 is out of range).
// Honours CLK_EN_GEN_SQUARE_EN to decide what clk_out should carry.
module tb_clk_en_gen;

    localparam int NUM_CH = 3;
    localparam int ACC_W  = 8;
    localparam int SETTLE = 4;
    localparam int MODV   = 1 << ACC_W;
    localparam int VW     = 2 * NUM_CH + 3;

    logic              refclk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic [ACC_W-1:0]  cfg_phase;
    logic              cfg_err;
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] clk_out;
    logic              locked;

    clk_en_gen #(
        .NUM_CH        (NUM_CH),
        .ACC_W         (ACC_W),
        .SETTLE_CYCLES (SETTLE),
        .INC_RST       (8'd64)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_phase (cfg_phase),
        .cfg_err   (cfg_err),
        .en_out    (en_out),
        .clk_out   (clk_out),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: arithmetic accumulators plus cycles elapsed since the last settle restart.
    int                m_acc [NUM_CH];
    int                m_inc [NUM_CH];
    int                since;
    bit                m_lock;
    bit                m_err;
    logic [NUM_CH-1:0] m_en;
    logic [NUM_CH-1:0] m_clk;
    bit                last_acc;

    logic [VW-1:0] act;
    assign act = {en_out, clk_out, locked, cfg_ready, cfg_err};

    function automatic logic [VW-1:0] exp_vec();
        return {m_en, m_clk, m_lock, m_lock, m_err};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_acc[c] = 0;
            m_inc[c] = 64;
        end
        since  = 0;
        m_lock = 0;
        m_err  = 0;
        m_en   = '0;
        m_clk  = '0;
    endtask

    task automatic model_edge(output bit accepted);
        bit pre_lock;
        bit hit;
        bit rej;
        int sum;
        logic [NUM_CH-1:0] carry;
        pre_lock = (since >= SETTLE);
        hit = cfg_valid && pre_lock && (int'(cfg_ch) < NUM_CH);
        rej = cfg_valid && pre_lock && (int'(cfg_ch) >= NUM_CH);
        for (int c = 0; c < NUM_CH; c++) begin
            if (hit && int'(cfg_ch) == c) begin
                m_inc[c] = int'(cfg_inc);
                m_acc[c] = int'(cfg_phase);
                carry[c] = 1'b0;
            end else begin
                sum      = m_acc[c] + m_inc[c];
                carry[c] = (sum >= MODV);
                m_acc[c] = sum % MODV;
            end
        end
        if (hit) since = 0;
        else if (since < 100000) since = since + 1;
        m_lock = (since >= SETTLE);
        for (int c = 0; c < NUM_CH; c++) begin
            m_en[c] = carry[c] && m_lock;
`ifdef CLK_EN_GEN_SQUARE_EN
            m_clk[c] = m_lock && (m_acc[c] >= MODV / 2);
`else
            m_clk[c] = 1'b0;
`endif
        end
        m_err    = rej;
        accepted = hit;
    endtask

    task automatic step();
        bit a;
        model_edge(a);
        last_acc = a;
        @(posedge refclk);
        @(negedge refclk);
    endtask

    task automatic drive_cfg(input bit v, input int ch, input int inc, input int ph);
        cfg_valid = v;
        cfg_ch    = 2'(ch);
        cfg_inc   = ACC_W'(inc);
        cfg_phase = ACC_W'(ph);
    endtask

    // Reset values, then locked rising exactly at the SETTLE-th edge after release.
    task automatic test_reset();
        int first_lock;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (act !== exp_vec()) begin
            n_fail++;
            $display("[TB] FAIL reset_values: got %b expected %b", act, exp_vec());
        end
        @(negedge refclk);
        rst = 1'b0;
        first_lock = -1;
        for (int k = 1; k <= SETTLE + 2; k++) begin
            step();
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL reset_settle k=%0d: got %b expected %b", k, act, exp_vec());
            end
            if (locked === 1'b1 && first_lock < 0) first_lock = k;
        end
        n_checks++;
        if (first_lock !== SETTLE) begin
            n_fail++;
            $display("[TB] FAIL reset_lock_edge: got %0d expected %0d", first_lock, SETTLE);
        end
    endtask

    // inc=64 at reset: one pulse every 4 cycles on every channel.
    task automatic test_base_rate();
        int cnt0;
        cnt0 = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL base_rate k=%0d: got %b expected %b", k, act, exp_vec());
            end
            if (en_out[0] === 1'b1) cnt0++;
        end
        n_checks++;
        if (cnt0 !== 10) begin
            n_fail++;
            $display("[TB] FAIL base_rate_count: got %0d expected 10", cnt0);
        end
    endtask

    // Square-wave output, or constant zero when the feature is not built.
    task automatic test_square();
        logic s [24];
        int   highs;
        highs = 0;
        for (int k = 0; k < 24; k++) begin
            step();
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL square k=%0d: got %b expected %b", k, act, exp_vec());
            end
            s[k] = clk_out[0];
            if (clk_out[0] === 1'b1) highs++;
        end
`ifdef CLK_EN_GEN_SQUARE_EN
        n_checks++;
        if (highs !== 12) begin
            n_fail++;
            $display("[TB] FAIL square_duty: got %0d highs expected 12", highs);
        end
        for (int k = 0; k < 20; k++) begin
            n_checks++;
            if (s[k] === s[k + 2] || s[k] !== s[k + 4]) begin
                n_fail++;
                $display("[TB] FAIL square_shape k=%0d: got %b,%b,%b", k, s[k], s[k + 2], s[k + 4]);
            end
        end
`else
        n_checks++;
        if (highs !== 0) begin
            n_fail++;
            $display("[TB] FAIL clk_out_tied: got %0d highs expected 0", highs);
        end
`endif
    endtask

    // Reprogram ch1 to inc=32: 4 unlocked cycles, ch1 period 8, ch0 period 4.
    task automatic test_reprogram();
        int lows;
        int c0;
        int c1;
        lows = 0;
        c0   = 0;
        c1   = 0;
        drive_cfg(1, 1, 32, 0);
        step();
        drive_cfg(0, 0, 0, 0);
        if (locked === 1'b0) lows++;
        for (int k = 0; k < SETTLE; k++) begin
            step();
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL reprog_settle k=%0d: got %b expected %b", k, act, exp_vec());
            end
            if (locked === 1'b0) lows++;
        end
        n_checks++;
        if (lows !== SETTLE) begin
            n_fail++;
            $display("[TB] FAIL reprog_unlocked: got %0d cycles expected %0d", lows, SETTLE);
        end
        for (int k = 0; k < 64; k++) begin
            step();
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL reprog_run k=%0d: got %b expected %b", k, act, exp_vec());
            end
            if (en_out[0] === 1'b1) c0++;
            if (en_out[1] === 1'b1) c1++;
        end
        n_checks++;
        if (c0 !== 16 || c1 !== 8) begin
            n_fail++;
            $display("[TB] FAIL reprog_rates: got ch0=%0d ch1=%0d expected 16 and 8", c0, c1);
        end
    endtask

    // cfg_valid held across settle is taken on the first locked cycle.
    task automatic test_held_valid();
        int when;
        when = -1;
        drive_cfg(1, 2, 16, 5);
        step();
        drive_cfg(1, 2, 64, 0);
        for (int k = 1; k <= 20; k++) begin
            step();
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL held_valid k=%0d: got %b expected %b", k, act, exp_vec());
            end
            if (last_acc) begin
                when = k;
                break;
            end
        end
        drive_cfg(0, 0, 0, 0);
        n_checks++;
        if (when !== SETTLE + 1) begin
            n_fail++;
            $display("[TB] FAIL held_valid_accept: got cycle %0d expected %0d", when, SETTLE + 1);
        end
        repeat (SETTLE) step();
    endtask

    // Out-of-range channel: one-cycle error, lock and rates untouched.
    task automatic test_bad_channel();
        drive_cfg(1, 3, $urandom_range(0, 255), $urandom_range(0, 255));
        step();
        drive_cfg(0, 0, 0, 0);
        n_checks++;
        if (cfg_err !== 1'b1 || locked !== 1'b1 || act !== exp_vec()) begin
            n_fail++;
            $display("[TB] FAIL bad_ch_pulse: got %b expected %b", act, exp_vec());
        end
        step();
        n_checks++;
        if (cfg_err !== 1'b0 || act !== exp_vec()) begin
            n_fail++;
            $display("[TB] FAIL bad_ch_clear: got %b expected %b", act, exp_vec());
        end
        for (int k = 0; k < 16; k++) begin
            step();
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL bad_ch_after k=%0d: got %b expected %b", k, act, exp_vec());
            end
        end
    endtask

    // inc=0 never pulses.
    task automatic test_zero_inc();
        int c0;
        c0 = 0;
        drive_cfg(1, 0, 0, 0);
        step();
        drive_cfg(0, 0, 0, 0);
        for (int k = 0; k < 1000; k++) begin
            step();
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL zero_inc k=%0d: got %b expected %b", k, act, exp_vec());
            end
            if (en_out[0] === 1'b1) c0++;
        end
        n_checks++;
        if (c0 !== 0) begin
            n_fail++;
            $display("[TB] FAIL zero_inc_count: got %0d expected 0", c0);
        end
    endtask

    // inc=255 pulses 255 times in any 256-cycle locked window.
    task automatic test_full_inc();
        int c0;
        c0 = 0;
        drive_cfg(1, 0, 255, 0);
        step();
        drive_cfg(0, 0, 0, 0);
        repeat (SETTLE) step();
        for (int k = 0; k < 256; k++) begin
            step();
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL full_inc k=%0d: got %b expected %b", k, act, exp_vec());
            end
            if (en_out[0] === 1'b1) c0++;
        end
        n_checks++;
        if (c0 !== 255) begin
            n_fail++;
            $display("[TB] FAIL full_inc_count: got %0d expected 255", c0);
        end
    endtask

    // Async reset mid-settle and mid-pulse clears everything and restarts the settle window.
    task automatic test_reset_mid();
        int first_lock;
        int hunt;
        int cnts [NUM_CH];
        drive_cfg(1, 1, 100, 0);
        step();
        drive_cfg(0, 0, 0, 0);
        step();
        step();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (act !== '0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_settle: got %b expected all zero", act);
        end
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        first_lock = -1;
        for (int k = 1; k <= SETTLE + 1; k++) begin
            step();
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL rst_resettle k=%0d: got %b expected %b", k, act, exp_vec());
            end
            if (locked === 1'b1 && first_lock < 0) first_lock = k;
        end
        n_checks++;
        if (first_lock !== SETTLE) begin
            n_fail++;
            $display("[TB] FAIL rst_relock_edge: got %0d expected %0d", first_lock, SETTLE);
        end
        hunt = 0;
        while (en_out === '0 && hunt < 16) begin
            step();
            hunt++;
        end
        n_checks++;
        if (en_out === '0) begin
            n_fail++;
            $display("[TB] FAIL rst_pulse_search: got no pulse within %0d cycles", hunt);
        end
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (act !== '0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_pulse: got %b expected all zero", act);
        end
        @(negedge refclk);
        rst = 1'b0;
        repeat (SETTLE) step();
        for (int c = 0; c < NUM_CH; c++) cnts[c] = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL rst_after k=%0d: got %b expected %b", k, act, exp_vec());
            end
            for (int c = 0; c < NUM_CH; c++) if (en_out[c] === 1'b1) cnts[c]++;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            n_checks++;
            if (cnts[c] !== 2) begin
                n_fail++;
                $display("[TB] FAIL rst_inc_restored ch%0d: got %0d pulses expected 2", c, cnts[c]);
            end
        end
    endtask

    // Random config traffic against the model.
    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 5) == 0)
                drive_cfg(1, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
            else
                drive_cfg(0, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
            step();
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL random k=%0d: got %b expected %b", k, act, exp_vec());
            end
        end
        drive_cfg(0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        drive_cfg(0, 0, 0, 0);
        model_reset();
        test_reset();
        test_base_rate();
        test_square();
        test_reprogram();
        test_held_valid();
        test_bad_channel();
        test_zero_inc();
        test_full_inc();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
